// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for rr_lock_arbiter.
// rr_pick returns {found, idx} searching req circularly from ptr over n bits.
package arb_pkg;

  localparam int MAXN = 16;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(
    input logic [MAXN-1:0] req,
    input logic [3:0]      ptr,
    input int              n
  );
    pick_t r;
    int    j;
    r = '0;
    // Walk offsets high to low so the
    // nearest set bit from ptr wins.
    for (int i = n - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (req[j]) begin
        r.found = 1'b1;
        r.idx   = 4'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_if.sv
// Request/grant bundle between arbiter and its users.
// dut drives grant/grant_valid/grant_id/preempt; tb drives reset/request.
interface arb_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic           reset;
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;

  modport dut (
    input  reset, request,
    output grant, grant_valid, grant_id, preempt
  );

  modport tb (
    output reset, request,
    input  grant, grant_valid, grant_id, preempt
  );
endinterface

// File: rtl/rr_pick_logic.sv
// Combinational circular priority encoder.
// req/ptr in; found, idx = first set bit at or after ptr (wrapping).
module rr_pick_logic
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking and a hold limit.
// clk/reset; request[N] in; grant, grant_valid, grant_id, preempt out.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt
);

  localparam int CW =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE = N'(1);

  arb_state_t     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pre_q, pre_d;

  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] pick_ptr;
  logic           pk_found;
  logic [IDW-1:0] pk_idx;
  logic           own_req;
  logic           at_lim;

  // Pointer just past the owner; the old
  // owner therefore ranks last on release.
  assign nxt_ptr =
    (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
  assign pick_ptr =
    (state_q == BUSY) ? nxt_ptr : ptr_q;

  rr_pick_logic #(.N(N), .IDW(IDW)) u_pick (
    .req   (request),
    .ptr   (pick_ptr),
    .found (pk_found),
    .idx   (pk_idx)
  );

  assign own_req = request[id_q];
  assign at_lim  = (MAX_HOLD != 0) && (cnt_q == LIM);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pk_found) begin
          state_d = BUSY;
          grant_d = ONE << pk_idx;
          id_d    = pk_idx;
          cnt_d   = CW'(1);
        end else begin
          grant_d = '0;
          id_d    = '0;
        end
      end
      BUSY: begin
        if (own_req && !at_lim) begin
          if (MAX_HOLD != 0)
            cnt_d = cnt_q + 1'b1;
        end else begin
          pre_d = own_req;
          ptr_d = nxt_ptr;
          if (pk_found) begin
            grant_d = ONE << pk_idx;
            id_d    = pk_idx;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign preempt     = pre_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter, N=4, MAX_HOLD=8.
// Each task drives one scenario and checks outputs after each edge.
module tb_rr_lock_arbiter;
  import arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  arb_if #(.N(N)) bus ();

  rr_lock_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset       (bus.reset),
    .request     (bus.request),
    .grant       (bus.grant),
    .grant_valid (bus.grant_valid),
    .grant_id    (bus.grant_id),
    .preempt     (bus.preempt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.reset   = 1'b1;
    bus.request = '0;
    step();
    bus.reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.reset   = 1'b1;
    bus.request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_run++;
      if (bus.grant !== 4'b0000 ||
          bus.grant_valid !== 1'b0 ||
          bus.grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got g=%b v=%b id=%0d want 0000/0/0",
                 i, bus.grant, bus.grant_valid, bus.grant_id);
      end
    end
    bus.reset = 1'b0;
    step();
    n_run++;
    if (bus.grant !== 4'b0001 ||
        bus.grant_valid !== 1'b1 ||
        bus.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got g=%b v=%b id=%0d want 0001/1/0",
               bus.grant, bus.grant_valid, bus.grant_id);
    end
  endtask

  task automatic test_single_release();
    do_reset();
    bus.request = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_run++;
      if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got g=%b id=%0d want 0100/2",
                 i, bus.grant, bus.grant_id);
      end
    end
    bus.request = 4'b0000;
    step();
    n_run++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 ||
        bus.preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: got g=%b v=%b p=%b want 0000/0/0",
               bus.grant, bus.grant_valid, bus.preempt);
    end
    bus.request = 4'b1001;
    step();
    n_run++;
    if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL ptr_after_2: got g=%b id=%0d want 1000/3",
               bus.grant, bus.grant_id);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] eg;
    logic       ep;
    int         bad;
    do_reset();
    bus.request = 4'b1111;
    step();
    bad = 0;
    for (int o = 0; o < 5; o++) begin
      for (int c = 1; c <= 8; c++) begin
        eg = 4'b0001 << (o % 4);
        ep = (c == 1 && o != 0);
        n_run++;
        if (bus.grant !== eg || bus.preempt !== ep ||
            bus.grant_id !== 2'(o % 4)) begin
          n_fail++;
          bad++;
          if (bad < 6)
            $display("FAIL rotate o=%0d c=%0d: got g=%b p=%b id=%0d want %b/%b/%0d",
                     o, c, bus.grant, bus.preempt, bus.grant_id,
                     eg, ep, o % 4);
        end
        if (!(o == 4 && c == 8))
          step();
      end
    end
  endtask

  task automatic test_back_to_back();
    pick_t exp;
    do_reset();
    bus.request = 4'b0010;
    step();
    step();
    n_run++;
    if (bus.grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_owner: got g=%b want 0010", bus.grant);
    end
    bus.request = 4'b0101;
    exp = rr_pick(16'(4'b0101), 4'd2, N);
    step();
    n_run++;
    if (bus.grant !== (4'b0001 << exp.idx) ||
        bus.grant !== 4'b0100 || bus.grant_valid !== 1'b1 ||
        bus.preempt !== 1'b0 || !exp.found) begin
      n_fail++;
      $display("FAIL b2b_move: got g=%b v=%b p=%b want 0100/1/0",
               bus.grant, bus.grant_valid, bus.preempt);
    end
  endtask

  task automatic test_sole_preempt();
    int pulses;
    logic ep;
    do_reset();
    bus.request = 4'b0010;
    pulses = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      ep = (s == 9 || s == 17);
      if (bus.preempt === 1'b1) pulses++;
      n_run++;
      if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1 ||
          bus.preempt !== ep) begin
        n_fail++;
        $display("FAIL sole[%0d]: got g=%b id=%0d p=%b want 0010/1/%b",
                 s, bus.grant, bus.grant_id, bus.preempt, ep);
      end
    end
    n_run++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL sole_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.request = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    n_run++;
    if (bus.grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL rb_owner: got g=%b want 1000", bus.grant);
    end
    bus.reset = 1'b1;
    step();
    n_run++;
    if (bus.grant !== 4'b0000 || bus.preempt !== 1'b0 ||
        bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_reset: got g=%b v=%b p=%b want 0000/0/0",
               bus.grant, bus.grant_valid, bus.preempt);
    end
    bus.reset   = 1'b0;
    bus.request = 4'b1010;
    step();
    n_run++;
    if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL rb_ptr0: got g=%b id=%0d want 0010/1",
               bus.grant, bus.grant_id);
    end
  endtask

  initial begin
    bus.reset   = 1'b1;
    bus.request = '0;
    test_reset();
    test_single_release();
    test_rotate();
    test_back_to_back();
    test_sole_preempt();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
